// File: rtl/mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mon_pkg
// Description : Shared definitions for the Montgomery multiplier and the
//               exponentiation controller that drives it. It holds the
//               default operand width, the default iteration-counter width
//               and the three-state encoding of the multiplier sequencer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mon_pkg;

  // Default operand/modulus width N.
  localparam int DEF_BITLEN     = 64;
  // Default iteration-counter width; 2**DEF_LOG_BITLEN must exceed DEF_BITLEN.
  localparam int DEF_LOG_BITLEN = 10;

  // Sequencer states. The encoding is fixed because the controller reuses it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    CORR = 2'd2
  } state_t;

endpackage : mon_pkg
`default_nettype wire

// File: rtl/mont_mul_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul_engine_if
// Description : start/stop handshake and operand bus between the
//               exponentiation controller (master) and the Montgomery
//               multiplier (slave).
// Signals     : start - request, one cycle or held, seen only when idle
//               A, B  - operands, both below M
//               M     - odd modulus, greater than 1
//               stop  - one-cycle completion pulse
//               P     - result A*B*2^-BITLEN mod M, valid with stop
// Revision    : 1.0 - initial release
// ============================================================================
interface mont_mul_engine_if
  import mon_pkg::*;
#(
  parameter int BITLEN = DEF_BITLEN
);

  logic              start;
  logic [BITLEN-1:0] A;
  logic [BITLEN-1:0] B;
  logic [BITLEN-1:0] M;
  logic              stop;
  logic [BITLEN-1:0] P;

  modport master (
    output start, A, B, M,
    input  stop, P
  );

  modport slave (
    input  start, A, B, M,
    output stop, P
  );

endinterface : mont_mul_engine_if
`default_nettype wire

// File: rtl/mont_step.sv
`default_nettype none
// ============================================================================
// Module      : mont_step
// Description : One radix-2 Montgomery iteration, purely combinational.
//                 t      = s + (a_bit ? b : 0)
//                 s_next = (t + (t[0] ? m : 0)) / 2
// Ports       : s      - accumulator in, BITLEN+2 bits
//               a_bit  - current multiplicand bit
//               b      - multiplier
//               m      - modulus (odd)
//               s_next - accumulator out, BITLEN+2 bits
// Revision    : 1.0 - initial release
// ============================================================================
module mont_step
  import mon_pkg::*;
#(
  parameter int BITLEN = DEF_BITLEN
) (
  input  logic [BITLEN+1:0] s,
  input  logic              a_bit,
  input  logic [BITLEN-1:0] b,
  input  logic [BITLEN-1:0] m,
  output logic [BITLEN+1:0] s_next
);

  localparam int W = BITLEN + 2;

  logic [W-1:0] t;
  logic [W-1:0] u;

  // With s < 2m on entry, t < 3m and u < 4m, so BITLEN+2 bits never
  // overflow and s_next < 2m keeps the invariant for the next iteration.
  assign t      = s + (a_bit ? {2'b00, b} : {W{1'b0}});
  assign u      = t + (t[0]  ? {2'b00, m} : {W{1'b0}});
  assign s_next = u >> 1;

endmodule : mont_step
`default_nettype wire

// File: rtl/mont_mul_engine.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul_engine
// Description : Bit-serial radix-2 Montgomery multiplier. Computes
//               P = A*B*2^-BITLEN mod M in BITLEN+1 cycles after the edge
//               that accepts start, then pulses stop for one cycle.
//               Operands are captured on the accepting edge, so later bus
//               changes do not disturb an operation in flight.
// Ports       : clk - clock, rising edge
//               rst - synchronous active-high reset
//               bus - slave side of mont_mul_engine_if
//                     (start, A, B, M in; stop, P out)
// Revision    : 1.0 - initial release
// ============================================================================
module mont_mul_engine
  import mon_pkg::*;
#(
  parameter int BITLEN     = DEF_BITLEN,
  parameter int LOG_BITLEN = DEF_LOG_BITLEN
) (
  input  logic              clk,
  input  logic              rst,
  mont_mul_engine_if.slave  bus
);

  localparam logic [LOG_BITLEN-1:0] LAST_ITER = LOG_BITLEN'(BITLEN - 1);

  state_t                  state;
  logic [BITLEN-1:0]       a_sr;      // multiplicand, shifted right each iteration
  logic [BITLEN-1:0]       b_reg;
  logic [BITLEN-1:0]       m_reg;
  logic [BITLEN+1:0]       s;         // accumulator
  logic [LOG_BITLEN-1:0]   i;         // iteration counter
  logic                    stop_q;
  logic [BITLEN-1:0]       p_q;

  logic [BITLEN+1:0]       s_next;
  logic [BITLEN+1:0]       s_minus_m;
  logic [BITLEN-1:0]       p_next;

  // a_sr[0] is the bit A_reg[i] of the current iteration, because the
  // register shifts right once per LOOP cycle.
  mont_step #(
    .BITLEN (BITLEN)
  ) u_step (
    .s      (s),
    .a_bit  (a_sr[0]),
    .b      (b_reg),
    .m      (m_reg),
    .s_next (s_next)
  );

  // Final correction: the loop leaves s < 2m, so one conditional
  // subtraction brings the result into [0, m).
  assign s_minus_m = s - {2'b00, m_reg};
  assign p_next    = (s >= {2'b00, m_reg}) ? s_minus_m[BITLEN-1:0] : s[BITLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      s      <= '0;
      i      <= '0;
      stop_q <= 1'b0;
      p_q    <= '0;
    end else begin
      stop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.A;
            b_reg <= bus.B;
            m_reg <= bus.M;
            s     <= '0;
            i     <= '0;
            state <= LOOP;
          end
        end

        LOOP: begin
          s    <= s_next;
          a_sr <= a_sr >> 1;
          i    <= i + 1'b1;
          if (i == LAST_ITER) begin
            state <= CORR;
          end
        end

        CORR: begin
          p_q    <= p_next;
          stop_q <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stop = stop_q;
  assign bus.P    = p_q;

endmodule : mont_mul_engine
`default_nettype wire
